bht_update_scheduler: RTL and testbench

BHT_UPDATE_SCHEDULER -- requirements
Module: bht_update_scheduler

---
 rtl/bht_update_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_bht_update_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_scheduler.sv
// bht_update_scheduler
// Shares one single-port table of 2-bit saturating counters between branch
// lookups and a small queue of resolved-branch feedback updates. After reset
// the table is swept to weakly-not-taken. Updates are read-modify-write
// (UPD_RD then UPD_WR). Lookups win arbitration unless the queue is full or
// has starved for STARVE_LIMIT consecutive grants.
// Optional build macro: BHT_SCHED_STATS_EN adds o_stall_cnt (32-bit count of
// cycles with a lookup request pending but not accepted).
module bht_update_scheduler #(
  parameter int INDEX_BITS   = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [INDEX_BITS-1:0] i_req_index,
  output logic                  o_req_ready,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  input  logic                  i_fb_valid,
  input  logic [INDEX_BITS-1:0] i_fb_index,
  input  logic                  i_fb_taken,
  output logic                  o_fb_ready,
  output logic                  tbl_en,
  output logic                  tbl_we,
  output logic [INDEX_BITS-1:0] tbl_addr,
  output logic [1:0]            tbl_wdata,
  input  logic [1:0]            tbl_rdata,
  output logic                  o_init_done
`ifdef BHT_SCHED_STATS_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPD_RD = 2'd2;
  localparam logic [1:0] ST_UPD_WR = 2'd3;

  localparam logic [INDEX_BITS-1:0] ADDR_ONE = 1;
  localparam logic [INDEX_BITS-1:0] ADDR_MAX = '1;
  localparam logic [PTR_W-1:0]      PTR_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0]      STV_ONE  = 1;
  localparam logic [STV_W-1:0]      STV_MAX  = STV_W'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] init_addr_q, init_addr_d;
  logic                  init_done_q, init_done_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [STV_W-1:0]      starve_q;
  logic                  pred_valid_q;

  logic [INDEX_BITS-1:0] fifo_idx_q [FIFO_DEPTH];
  logic                  fifo_tkn_q [FIFO_DEPTH];

  logic                  fifo_empty, fifo_full, push, pop;
  logic                  upd_sel, grant;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_tkn;
  logic [1:0]            upd_val;
  logic                  tbl_en_raw, tbl_we_raw;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign o_fb_ready = ~fifo_full;
  assign push       = i_fb_valid & ~fifo_full;
  assign pop        = (state_q == ST_UPD_WR);
  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_tkn   = fifo_tkn_q[rd_ptr_q];

  // Update wins when nothing else wants the table, or it can no longer wait.
  assign upd_sel     = (state_q == ST_IDLE) & ~fifo_empty &
                       (~i_req_valid | fifo_full | (starve_q == STV_MAX));
  assign o_req_ready = (state_q == ST_IDLE) & ~upd_sel;
  assign grant       = i_req_valid & o_req_ready;

  assign o_pred_valid = pred_valid_q;
  assign o_pred_taken = pred_valid_q & tbl_rdata[1];
  assign o_init_done  = init_done_q;

  // Saturating counter step for the head entry, from the value read in UPD_RD.
  always_comb begin
    upd_val = tbl_rdata;
    if (head_tkn) begin
      if (tbl_rdata != 2'b11) upd_val = tbl_rdata + 2'b01;
    end else begin
      if (tbl_rdata != 2'b00) upd_val = tbl_rdata - 2'b01;
    end
  end

  // Next-state logic: sweep, then idle arbitration, then two-cycle update.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + ADDR_ONE;
        if (init_addr_q == ADDR_MAX) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE:   if (upd_sel) state_d = ST_UPD_RD;
      ST_UPD_RD: state_d = ST_UPD_WR;
      ST_UPD_WR: state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  // Table port steering; the enables are forced off while reset is held.
  always_comb begin
    tbl_en_raw = 1'b0;
    tbl_we_raw = 1'b0;
    tbl_addr   = i_req_index;
    tbl_wdata  = upd_val;
    case (state_q)
      ST_INIT: begin
        tbl_en_raw = 1'b1;
        tbl_we_raw = 1'b1;
        tbl_addr   = init_addr_q;
        tbl_wdata  = 2'b01;
      end
      ST_IDLE: tbl_en_raw = grant;
      ST_UPD_RD: begin
        tbl_en_raw = 1'b1;
        tbl_addr   = head_idx;
      end
      ST_UPD_WR: begin
        tbl_en_raw = 1'b1;
        tbl_we_raw = 1'b1;
        tbl_addr   = head_idx;
      end
      default: ;
    endcase
  end

  assign tbl_en = tbl_en_raw & ~rst;
  assign tbl_we = tbl_we_raw & ~rst;

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
    end
  end

  // Queue pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue payload storage; one write port, selected by the write pointer.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          fifo_idx_q[gi] <= i_fb_index;
          fifo_tkn_q[gi] <= i_fb_taken;
        end
      end
    end
  endgenerate

  // Starvation counter: lookups granted while updates are waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (upd_sel || fifo_empty) begin
      starve_q <= '0;
    end else if (grant) begin
      starve_q <= starve_q + STV_ONE;
    end
  end

  // Prediction valid follows the lookup grant by the table read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pred_valid_q <= 1'b0;
    else     pred_valid_q <= grant;
  end

`ifdef BHT_SCHED_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles a lookup is held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (i_req_valid && !o_req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bht_update_scheduler.sv
// tb_bht_update_scheduler
// Directed bench for bht_update_scheduler (INDEX_BITS=4, FIFO_DEPTH=4,
// STARVE_LIMIT=8) with a behavioural 16x2-bit table that has a registered read.
// Define BHT_SCHED_STATS_EN to also check o_stall_cnt.
module tb_bht_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid;
  logic [3:0] i_req_index;
  logic       o_req_ready;
  logic       o_pred_valid;
  logic       o_pred_taken;
  logic       i_fb_valid;
  logic [3:0] i_fb_index;
  logic       i_fb_taken;
  logic       o_fb_ready;
  logic       tbl_en;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata;
  logic       o_init_done;
`ifdef BHT_SCHED_STATS_EN
  logic [31:0] o_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bht_update_scheduler #(
    .INDEX_BITS  (4),
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_index (i_req_index),
    .o_req_ready (o_req_ready),
    .o_pred_valid(o_pred_valid),
    .o_pred_taken(o_pred_taken),
    .i_fb_valid  (i_fb_valid),
    .i_fb_index  (i_fb_index),
    .i_fb_taken  (i_fb_taken),
    .o_fb_ready  (o_fb_ready),
    .tbl_en      (tbl_en),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_wdata   (tbl_wdata),
    .tbl_rdata   (tbl_rdata),
    .o_init_done (o_init_done)
`ifdef BHT_SCHED_STATS_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  // Table model: single port, write-or-read, read data one cycle later.
  logic [1:0] mem [16] = '{default: 2'b10};
  logic [1:0] rdata_q = 2'b00;
  logic       log_en = 1'b0;
  logic [3:0] wlog [$];

  assign tbl_rdata = rdata_q;

  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) begin
        mem[tbl_addr] <= tbl_wdata;
        if (log_en) wlog.push_back(tbl_addr);
      end else begin
        rdata_q <= mem[tbl_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk %s got=%0h exp=%0h ok", tag, got, exp);
    end
  endtask

  // Push one feedback entry; call at posedge+1, returns at the next posedge+1.
  task automatic fb(input logic [3:0] idx, input logic tkn);
    i_fb_valid = 1'b1;
    i_fb_index = idx;
    i_fb_taken = tkn;
    @(posedge clk); #1;
    i_fb_valid = 1'b0;
  endtask

  // With no lookup pending, ready only returns once the queue has drained.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, o_req_ready}, 32'd1);
  endtask

  // Single lookup from an idle, empty-queue negedge; ends at a negedge.
  task automatic lookup(input logic [3:0] idx, input logic exp_t, input string tag);
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_index = idx;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_pv"}, {31'd0, o_pred_valid}, 32'd1);
    chk({tag, "_pt"}, {31'd0, o_pred_taken}, {31'd0, exp_t});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    logic [3:0] exp_order [4];
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_index = '0;
    i_fb_valid  = 1'b0;
    i_fb_index  = '0;
    i_fb_taken  = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  {31'd0, o_req_ready},  32'd0);
    chk("rst_pred_valid", {31'd0, o_pred_valid}, 32'd0);
    chk("rst_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    chk("rst_init_done",  {31'd0, o_init_done},  32'd0);
    chk("rst_tbl_we",     {31'd0, tbl_we},       32'd0);
    chk("rst_tbl_en",     {31'd0, tbl_en},       32'd0);
    chk("rst_fb_ready",   {31'd0, o_fb_ready},   32'd1);

    // Init sweep with a lookup held pending at index 5.
    @(posedge clk); #1;
    rst         = 1'b0;
    i_req_valid = 1'b1;
    i_req_index = 4'd5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_we",    {31'd0, tbl_we},    32'd1);
      chk("init_addr",  {28'd0, tbl_addr}, i);
      chk("init_wdata", {30'd0, tbl_wdata}, 32'd1);
      chk("init_rdy",   {31'd0, o_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("init_done17", {31'd0, o_init_done}, 32'd1);
    chk("lk5_rdy",     {31'd0, o_req_ready}, 32'd1);
    chk("lk5_addr",    {28'd0, tbl_addr},    32'd5);
    chk("lk5_we",      {31'd0, tbl_we},      32'd0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    chk("lk5_pv", {31'd0, o_pred_valid}, 32'd1);
    chk("lk5_pt", {31'd0, o_pred_taken}, 32'd0);
    chk("init_mem15", {30'd0, mem[15]}, 32'd1);
`ifdef BHT_SCHED_STATS_EN
    chk("stall_cnt", o_stall_cnt, 32'd16);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("pv_pulse",  {31'd0, o_pred_valid}, 32'd0);
    chk("idle_noen", {31'd0, tbl_en},       32'd0);

    // Two taken updates at index 3, then two not-taken.
    @(posedge clk); #1;
    fb(4'd3, 1'b1);
    fb(4'd3, 1'b1);
    wait_idle("idle_t3");
    chk("mem3_inc", {30'd0, mem[3]}, 32'd3);
    lookup(4'd3, 1'b1, "lk3a");
    @(posedge clk); #1;
    fb(4'd3, 1'b0);
    fb(4'd3, 1'b0);
    wait_idle("idle_n3");
    chk("mem3_dec", {30'd0, mem[3]}, 32'd1);
    lookup(4'd3, 1'b0, "lk3b");

    // Saturation at both ends.
    @(posedge clk); #1;
    fb(4'd9, 1'b1);
    fb(4'd9, 1'b1);
    fb(4'd9, 1'b1);
    wait_idle("idle_s9");
    chk("mem9_sat", {30'd0, mem[9]}, 32'd3);
    lookup(4'd9, 1'b1, "lk9");
    @(posedge clk); #1;
    fb(4'd2, 1'b0);
    fb(4'd2, 1'b0);
    fb(4'd2, 1'b0);
    wait_idle("idle_s2");
    chk("mem2_sat", {30'd0, mem[2]}, 32'd0);
    lookup(4'd2, 1'b0, "lk2");

    // Queued update stays invisible to lookups.
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_index = 4'd6;
    i_fb_valid  = 1'b1;
    i_fb_index  = 4'd6;
    i_fb_taken  = 1'b1;
    @(negedge clk);
    chk("qi_rdy0", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    i_fb_valid = 1'b0;
    @(negedge clk);
    chk("qi_rdy1", {31'd0, o_req_ready},  32'd1);
    chk("qi_pv0",  {31'd0, o_pred_valid}, 32'd1);
    chk("qi_pt0",  {31'd0, o_pred_taken}, 32'd0);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    chk("qi_pv1", {31'd0, o_pred_valid}, 32'd1);
    chk("qi_pt1", {31'd0, o_pred_taken}, 32'd0);
    wait_idle("idle_qi");
    lookup(4'd6, 1'b1, "lk6");

    // Fill the queue under continuous lookup pressure.
    wlog.delete();
    log_en = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_index = 4'd0;
    fb(4'd10, 1'b1);
    fb(4'd11, 1'b0);
    fb(4'd12, 1'b1);
    i_fb_valid = 1'b1;
    i_fb_index = 4'd13;
    i_fb_taken = 1'b0;
    @(negedge clk);
    chk("fill_fbrdy3", {31'd0, o_fb_ready},  32'd1);
    chk("fill_rdy3",   {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    i_fb_valid = 1'b0;
    @(negedge clk);
    chk("full_fbrdy", {31'd0, o_fb_ready},  32'd0);
    chk("full_sel",   {31'd0, o_req_ready}, 32'd0);
    chk("full_noen",  {31'd0, tbl_en},      32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_rd_rdy",  {31'd0, o_req_ready}, 32'd0);
    chk("full_rd_en",   {31'd0, tbl_en},      32'd1);
    chk("full_rd_we",   {31'd0, tbl_we},      32'd0);
    chk("full_rd_addr", {28'd0, tbl_addr},    32'd10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_wr_rdy",   {31'd0, o_req_ready}, 32'd0);
    chk("full_wr_we",    {31'd0, tbl_we},      32'd1);
    chk("full_wr_addr",  {28'd0, tbl_addr},    32'd10);
    chk("full_wr_wdata", {30'd0, tbl_wdata},   32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_resume", {31'd0, o_req_ready}, 32'd1);
    chk("full_fbrdy2", {31'd0, o_fb_ready},  32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_idle("idle_fill");
    log_en = 1'b0;
    exp_order[0] = 4'd10;
    exp_order[1] = 4'd11;
    exp_order[2] = 4'd12;
    exp_order[3] = 4'd13;
    chk("order_len", wlog.size(), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      chk("order_addr", {28'd0, wlog[k]}, {28'd0, exp_order[k]});
    end
    chk("mem10", {30'd0, mem[10]}, 32'd2);
    chk("mem11", {30'd0, mem[11]}, 32'd0);
    chk("mem12", {30'd0, mem[12]}, 32'd2);
    chk("mem13", {30'd0, mem[13]}, 32'd0);

    // Starvation limit: one queued entry, lookups held high.
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_index = 4'd1;
    i_fb_valid  = 1'b1;
    i_fb_index  = 4'd4;
    i_fb_taken  = 1'b1;
    @(negedge clk);
    chk("st_rdy0", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    i_fb_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (o_req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("st_grants", n, 32'd8);
    m = 0;
    while (!o_req_ready && m < 10) begin
      m++;
      @(negedge clk);
    end
    chk("st_stall",  m, 32'd3);
    chk("st_resume", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_idle("idle_st");
    chk("mem4", {30'd0, mem[4]}, 32'd2);

    // Reset in the middle of an update write.
    @(posedge clk); #1;
    fb(4'd7, 1'b1);
    fb(4'd8, 1'b0);
    @(negedge clk);
    chk("rw_rd_we",   {31'd0, tbl_we},   32'd0);
    chk("rw_rd_addr", {28'd0, tbl_addr}, 32'd7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_wr_we",   {31'd0, tbl_we},   32'd1);
    chk("rw_wr_addr", {28'd0, tbl_addr}, 32'd7);
    rst = 1'b1;
    #1;
    chk("rw_rst_we",    {31'd0, tbl_we},      32'd0);
    chk("rw_rst_en",    {31'd0, tbl_en},      32'd0);
    chk("rw_rst_fbrdy", {31'd0, o_fb_ready},  32'd1);
    chk("rw_rst_done",  {31'd0, o_init_done}, 32'd0);
    @(posedge clk); #1;
    chk("rw_nowrite7", {30'd0, mem[7]}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rw_sweep_addr", {28'd0, tbl_addr}, i);
      chk("rw_sweep_we",   {31'd0, tbl_we},   32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rw_done",   {31'd0, o_init_done}, 32'd1);
    chk("rw_qempty", {31'd0, o_req_ready}, 32'd1);
    chk("rw_noen",   {31'd0, tbl_en},      32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
